// File: rtl/instr_line_fetch_if.sv
// Core-side OBI-style instruction fetch bus for instr_line_fetch.
// The core drives the request side (master); the fetch adapter responds (slave).
interface instr_line_fetch_if #(
   parameter int ADDR_WIDTH = 16
);
   logic                  instr_req_i;
   logic [ADDR_WIDTH-1:0] instr_addr_i;
   logic                  instr_gnt_o;
   logic                  instr_rvalid_o;
   logic [31:0]           instr_rdata_o;

   modport master (
      output instr_req_i, instr_addr_i,
      input  instr_gnt_o, instr_rvalid_o, instr_rdata_o
   );

   modport slave (
      input  instr_req_i, instr_addr_i,
      output instr_gnt_o, instr_rvalid_o, instr_rdata_o
   );
endinterface

// File: rtl/instr_line_fetch.sv
// Single-line instruction fetch buffer in front of the 128-bit RAM port A.
// Optional hit/miss counters are enabled by defining INSTR_LINE_FETCH_STATS_EN.
//
// state | meaning
// IDLE  | serve hits from the held line; on a miss issue one aligned line read
// FILL  | RAM data valid this cycle; capture line and tag, then return to IDLE
module instr_line_fetch #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   instr_line_fetch_if.slave     bus,
   input  logic                  flush_i,
   output logic                  ram_en_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   input  logic [LINE_WIDTH-1:0] ram_rdata_i,
   output logic [31:0]           hit_cnt_o,
   output logic [31:0]           miss_cnt_o
);

   if (LINE_WIDTH != 128) begin : g_bad_line_width
      $error("instr_line_fetch: LINE_WIDTH must be 128");
   end

   typedef enum logic {IDLE, FILL} state_t;

   state_t                state_q, state_d;
   logic [127:0]          line_q;
   logic [ADDR_WIDTH-5:0] tag_q;
   logic [ADDR_WIDTH-5:0] fill_tag_q;
   logic                  valid_q;
   logic                  rvalid_q;
   logic [31:0]           rdata_q;

   logic [ADDR_WIDTH-5:0] tag;
   logic [1:0]            word_sel;
   logic                  hit;
   logic                  gnt;
   logic                  ram_en;

   assign tag      = bus.instr_addr_i[ADDR_WIDTH-1:4];
   assign word_sel = bus.instr_addr_i[3:2];
   // A flush in the same cycle must not be served from the line it invalidates.
   assign hit      = valid_q && (tag_q == tag) && !flush_i;

   always_comb begin
      state_d = state_q;
      gnt     = 1'b0;
      ram_en  = 1'b0;
      if (!rst_i) begin
         case (state_q)
            IDLE: begin
               if (bus.instr_req_i) begin
                  if (hit) begin
                     gnt = 1'b1;
                  end else begin
                     ram_en  = 1'b1;
                     state_d = FILL;
                  end
               end
            end
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         line_q     <= '0;
         tag_q      <= '0;
         fill_tag_q <= '0;
         valid_q    <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q  <= state_d;
         rvalid_q <= gnt;
         if (gnt) begin
            rdata_q <= line_q[{word_sel, 5'b0} +: 32];
         end
         if (ram_en) begin
            fill_tag_q <= tag;
         end
         if (state_q == FILL) begin
            line_q  <= ram_rdata_i[127:0];
            tag_q   <= fill_tag_q;
            valid_q <= !flush_i;
         end else if (flush_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.instr_gnt_o    = gnt;
   assign bus.instr_rvalid_o = rvalid_q;
   assign bus.instr_rdata_o  = rdata_q;
   assign ram_en_o           = ram_en;
   assign ram_addr_o         = ram_en ? {tag, 4'b0000} : '0;

`ifdef INSTR_LINE_FETCH_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (gnt)    hit_cnt_q  <= hit_cnt_q + 32'd1;
         if (ram_en) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`else
   assign hit_cnt_o  = '0;
   assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_instr_line_fetch.sv
// Directed bench for instr_line_fetch: miss/fill latency, hits, replacement,
// flush and reset-during-fill, with a one-cycle-latency RAM line model.
module tb_instr_line_fetch;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          flush_i = 1'b0;
   logic          ram_en_o;
   logic [15:0]   ram_addr_o;
   logic [127:0]  ram_rdata_i = '0;
   logic [31:0]   hit_cnt_o;
   logic [31:0]   miss_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef INSTR_LINE_FETCH_STATS_EN
   localparam logic [31:0] EXP_HITS   = 32'd4;
   localparam logic [31:0] EXP_MISSES = 32'd1;
`else
   localparam logic [31:0] EXP_HITS   = 32'd0;
   localparam logic [31:0] EXP_MISSES = 32'd0;
`endif

   instr_line_fetch_if #(.ADDR_WIDTH(16)) bus ();

   instr_line_fetch #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .bus         (bus),
      .flush_i     (flush_i),
      .ram_en_o    (ram_en_o),
      .ram_addr_o  (ram_addr_o),
      .ram_rdata_i (ram_rdata_i),
      .hit_cnt_o   (hit_cnt_o),
      .miss_cnt_o  (miss_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // RAM image: byte i of the line at base is (base[7:0] - 0x40 + i).
   function automatic logic [127:0] line_for(input logic [15:0] a);
      logic [127:0] l;
      for (int i = 0; i < 16; i++) l[8*i +: 8] = 8'(a[7:0] - 8'h40 + 8'(i));
      return l;
   endfunction

   always @(posedge clk_i) if (ram_en_o) ram_rdata_i <= line_for(ram_addr_o);

   assert property (@(posedge clk_i) disable iff (rst_i)
      (bus.instr_req_i && !bus.instr_gnt_o) |=> (!bus.instr_req_i || $stable(bus.instr_addr_i)));

   assert property (@(posedge clk_i) disable iff (rst_i) ram_en_o |=> !ram_en_o);

   // One cycle: drive inputs after the falling edge, then let outputs settle.
   task automatic step(input logic req, input logic [15:0] addr, input logic fl, input logic rst);
      @(negedge clk_i);
      bus.instr_req_i  = req;
      bus.instr_addr_i = addr;
      flush_i          = fl;
      rst_i            = rst;
      #1;
   endtask

   task automatic test_reset();
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b1, 16'h0040, 1'b0, 1'b1);
      n_checks++; if (bus.instr_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0", bus.instr_gnt_o); end
      n_checks++; if (ram_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en got=%b exp=0", ram_en_o); end
      n_checks++; if (ram_addr_o !== 16'h0) begin n_fail++; $display("FAIL reset_ram_addr got=%h exp=0000", ram_addr_o); end
      n_checks++; if (bus.instr_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0", bus.instr_rvalid_o); end
      n_checks++; if (bus.instr_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", bus.instr_rdata_o); end
      n_checks++; if ({hit_cnt_o, miss_cnt_o} !== 64'h0) begin n_fail++; $display("FAIL reset_counters got=%h/%h exp=0/0", hit_cnt_o, miss_cnt_o); end
   endtask

   task automatic test_miss_and_hits();
      step(1'b1, 16'h0040, 1'b0, 1'b0);   // cycle 0
      n_checks++; if (ram_en_o !== 1'b1 || ram_addr_o !== 16'h0040) begin n_fail++; $display("FAIL miss_ram_req got=%b/%h exp=1/0040", ram_en_o, ram_addr_o); end
      n_checks++; if (bus.instr_gnt_o !== 1'b0) begin n_fail++; $display("FAIL miss_c0_gnt got=%b exp=0", bus.instr_gnt_o); end
      step(1'b1, 16'h0040, 1'b0, 1'b0);   // cycle 1 (FILL)
      n_checks++; if (bus.instr_gnt_o !== 1'b0 || ram_en_o !== 1'b0) begin n_fail++; $display("FAIL fill_c1 gnt/en got=%b/%b exp=0/0", bus.instr_gnt_o, ram_en_o); end
      step(1'b1, 16'h0040, 1'b0, 1'b0);   // cycle 2
      n_checks++; if (bus.instr_gnt_o !== 1'b1 || bus.instr_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL miss_c2 gnt/rvalid got=%b/%b exp=1/0", bus.instr_gnt_o, bus.instr_rvalid_o); end
      step(1'b1, 16'h0044, 1'b0, 1'b0);   // cycle 3
      n_checks++; if (bus.instr_rvalid_o !== 1'b1 || bus.instr_rdata_o !== 32'h03020100) begin n_fail++; $display("FAIL miss_c3_rdata got=%b/%h exp=1/03020100", bus.instr_rvalid_o, bus.instr_rdata_o); end
      n_checks++; if (bus.instr_gnt_o !== 1'b1 || ram_en_o !== 1'b0) begin n_fail++; $display("FAIL hit44 gnt/en got=%b/%b exp=1/0", bus.instr_gnt_o, ram_en_o); end
      step(1'b1, 16'h0048, 1'b0, 1'b0);
      n_checks++; if (bus.instr_gnt_o !== 1'b1 || ram_en_o !== 1'b0) begin n_fail++; $display("FAIL hit48 gnt/en got=%b/%b exp=1/0", bus.instr_gnt_o, ram_en_o); end
      n_checks++; if (bus.instr_rvalid_o !== 1'b1 || bus.instr_rdata_o !== 32'h07060504) begin n_fail++; $display("FAIL hit44_rdata got=%b/%h exp=1/07060504", bus.instr_rvalid_o, bus.instr_rdata_o); end
      step(1'b1, 16'h004C, 1'b0, 1'b0);
      n_checks++; if (bus.instr_gnt_o !== 1'b1 || ram_en_o !== 1'b0) begin n_fail++; $display("FAIL hit4c gnt/en got=%b/%b exp=1/0", bus.instr_gnt_o, ram_en_o); end
      n_checks++; if (bus.instr_rvalid_o !== 1'b1 || bus.instr_rdata_o !== 32'h0B0A0908) begin n_fail++; $display("FAIL hit48_rdata got=%b/%h exp=1/0B0A0908", bus.instr_rvalid_o, bus.instr_rdata_o); end
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      n_checks++; if (bus.instr_rvalid_o !== 1'b1 || bus.instr_rdata_o !== 32'h0F0E0D0C) begin n_fail++; $display("FAIL hit4c_rdata got=%b/%h exp=1/0F0E0D0C", bus.instr_rvalid_o, bus.instr_rdata_o); end
      n_checks++; if (hit_cnt_o !== EXP_HITS || miss_cnt_o !== EXP_MISSES) begin n_fail++; $display("FAIL stats hit/miss got=%0d/%0d exp=%0d/%0d", hit_cnt_o, miss_cnt_o, EXP_HITS, EXP_MISSES); end
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      n_checks++; if (bus.instr_rvalid_o !== 1'b0 || bus.instr_rdata_o !== 32'h0F0E0D0C) begin n_fail++; $display("FAIL idle_hold got=%b/%h exp=0/0F0E0D0C", bus.instr_rvalid_o, bus.instr_rdata_o); end
   endtask

   task automatic test_replace();
      step(1'b1, 16'h0050, 1'b0, 1'b0);
      n_checks++; if (ram_en_o !== 1'b1 || ram_addr_o !== 16'h0050 || bus.instr_gnt_o !== 1'b0) begin n_fail++; $display("FAIL miss50 en/addr/gnt got=%b/%h/%b exp=1/0050/0", ram_en_o, ram_addr_o, bus.instr_gnt_o); end
      step(1'b1, 16'h0050, 1'b0, 1'b0);
      step(1'b1, 16'h0050, 1'b0, 1'b0);
      n_checks++; if (bus.instr_gnt_o !== 1'b1) begin n_fail++; $display("FAIL miss50_gnt got=%b exp=1", bus.instr_gnt_o); end
      step(1'b1, 16'h0040, 1'b0, 1'b0);
      n_checks++; if (bus.instr_rvalid_o !== 1'b1 || bus.instr_rdata_o !== 32'h13121110) begin n_fail++; $display("FAIL miss50_rdata got=%b/%h exp=1/13121110", bus.instr_rvalid_o, bus.instr_rdata_o); end
      n_checks++; if (ram_en_o !== 1'b1 || ram_addr_o !== 16'h0040 || bus.instr_gnt_o !== 1'b0) begin n_fail++; $display("FAIL remiss40 en/addr/gnt got=%b/%h/%b exp=1/0040/0", ram_en_o, ram_addr_o, bus.instr_gnt_o); end
      step(1'b1, 16'h0040, 1'b0, 1'b0);
      step(1'b1, 16'h0040, 1'b0, 1'b0);
      n_checks++; if (bus.instr_gnt_o !== 1'b1) begin n_fail++; $display("FAIL remiss40_gnt got=%b exp=1", bus.instr_gnt_o); end
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      n_checks++; if (bus.instr_rvalid_o !== 1'b1 || bus.instr_rdata_o !== 32'h03020100) begin n_fail++; $display("FAIL remiss40_rdata got=%b/%h exp=1/03020100", bus.instr_rvalid_o, bus.instr_rdata_o); end
   endtask

   task automatic test_flush();
      step(1'b1, 16'h0044, 1'b1, 1'b0);   // flush with a would-be hit
      n_checks++; if (bus.instr_gnt_o !== 1'b0 || ram_en_o !== 1'b1 || ram_addr_o !== 16'h0040) begin n_fail++; $display("FAIL flush_hit gnt/en/addr got=%b/%b/%h exp=0/1/0040", bus.instr_gnt_o, ram_en_o, ram_addr_o); end
      step(1'b1, 16'h0044, 1'b1, 1'b0);   // flush during FILL
      n_checks++; if (bus.instr_gnt_o !== 1'b0 || ram_en_o !== 1'b0) begin n_fail++; $display("FAIL flush_fill gnt/en got=%b/%b exp=0/0", bus.instr_gnt_o, ram_en_o); end
      step(1'b1, 16'h0044, 1'b0, 1'b0);
      n_checks++; if (bus.instr_gnt_o !== 1'b0 || ram_en_o !== 1'b1 || ram_addr_o !== 16'h0040) begin n_fail++; $display("FAIL flush_refill gnt/en/addr got=%b/%b/%h exp=0/1/0040", bus.instr_gnt_o, ram_en_o, ram_addr_o); end
      step(1'b1, 16'h0044, 1'b0, 1'b0);
      step(1'b1, 16'h0044, 1'b0, 1'b0);
      n_checks++; if (bus.instr_gnt_o !== 1'b1) begin n_fail++; $display("FAIL flush_refill_gnt got=%b exp=1", bus.instr_gnt_o); end
      step(1'b0, 16'h0000, 1'b1, 1'b0);   // flush alone clears the line
      n_checks++; if (bus.instr_rvalid_o !== 1'b1 || bus.instr_rdata_o !== 32'h07060504) begin n_fail++; $display("FAIL flush_refill_rdata got=%b/%h exp=1/07060504", bus.instr_rvalid_o, bus.instr_rdata_o); end
      step(1'b1, 16'h0048, 1'b0, 1'b0);
      n_checks++; if (bus.instr_gnt_o !== 1'b0 || ram_en_o !== 1'b1) begin n_fail++; $display("FAIL post_flush_miss gnt/en got=%b/%b exp=0/1", bus.instr_gnt_o, ram_en_o); end
      step(1'b1, 16'h0048, 1'b0, 1'b0);
      step(1'b1, 16'h0048, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      n_checks++; if (bus.instr_rvalid_o !== 1'b1 || bus.instr_rdata_o !== 32'h0B0A0908) begin n_fail++; $display("FAIL post_flush_rdata got=%b/%h exp=1/0B0A0908", bus.instr_rvalid_o, bus.instr_rdata_o); end
   endtask

   task automatic test_reset_in_fill();
      step(1'b1, 16'h0050, 1'b0, 1'b0);
      n_checks++; if (ram_en_o !== 1'b1) begin n_fail++; $display("FAIL rst_fill_miss en got=%b exp=1", ram_en_o); end
      step(1'b1, 16'h0050, 1'b0, 1'b1);   // reset during FILL
      step(1'b0, 16'h0050, 1'b0, 1'b0);
      n_checks++; if (bus.instr_rvalid_o !== 1'b0 || ram_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_fill_after rvalid/en got=%b/%b exp=0/0", bus.instr_rvalid_o, ram_en_o); end
      n_checks++; if ({hit_cnt_o, miss_cnt_o} !== 64'h0) begin n_fail++; $display("FAIL rst_fill_counters got=%h/%h exp=0/0", hit_cnt_o, miss_cnt_o); end
      step(1'b1, 16'h0050, 1'b0, 1'b0);
      n_checks++; if (bus.instr_gnt_o !== 1'b0 || ram_en_o !== 1'b1 || ram_addr_o !== 16'h0050) begin n_fail++; $display("FAIL rst_fill_remiss gnt/en/addr got=%b/%b/%h exp=0/1/0050", bus.instr_gnt_o, ram_en_o, ram_addr_o); end
      step(1'b1, 16'h0050, 1'b0, 1'b0);
      step(1'b1, 16'h0050, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      n_checks++; if (bus.instr_rvalid_o !== 1'b1 || bus.instr_rdata_o !== 32'h13121110) begin n_fail++; $display("FAIL rst_fill_rdata got=%b/%h exp=1/13121110", bus.instr_rvalid_o, bus.instr_rdata_o); end
   endtask

   initial begin
      bus.instr_req_i  = 1'b0;
      bus.instr_addr_i = '0;
      test_reset();
      test_miss_and_hits();
      test_replace();
      test_flush();
      test_reset_in_fill();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_line_fetch.md
Name: instr_line_fetch

Overview:
Instruction-side fetch adapter between the core's 32-bit OBI-style instruction interface and the 128-bit read port A of the dual-port instruction/data RAM. It holds one 128-bit line plus its tag. Word requests that hit the held line are served without a RAM access. A miss issues one aligned line read to the RAM, captures the line, and then serves the word. `flush_i` (fence.i) invalidates the held line.

Parameters:
- ADDR_WIDTH, 16, byte-address width; must equal the RAM ADDR_WIDTH.
- LINE_WIDTH, 128, line width in bits; fixed at 128 (4 words); elaboration error otherwise.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- instr_req_i  in  1  core fetch request.
- instr_addr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- instr_gnt_o  out  1  request accepted this cycle (combinational).
- instr_rvalid_o  out  1  instr_rdata_o valid (registered).
- instr_rdata_o  out  32  fetched word.
- flush_i  in  1  invalidate held line.
- ram_en_o  out  1  RAM port A enable.
- ram_addr_o  out  ADDR_WIDTH  RAM port A byte address, 16-byte aligned.
- ram_rdata_i  in  LINE_WIDTH  RAM port A read data; valid 1 cycle after ram_en_o.
- hit_cnt_o  out  32  hit counter (optional feature).
- miss_cnt_o  out  32  miss counter (optional feature).

Behaviour:
- Derived fields:
  - tag = instr_addr_i[ADDR_WIDTH-1:4]
  - word select = instr_addr_i[3:2]
  - word w = line[32*w +: 32]; byte i of the line is RAM byte base+i.
- State: line_q[127:0], tag_q, valid_q, FSM state in {IDLE, FILL}.
- Reset (rst_i=1 at an edge):
  - state=IDLE, valid_q=0, line_q=0, tag_q=0.
  - instr_rvalid_o=0, instr_rdata_o=0.
  - ram_en_o=0, ram_addr_o=0, instr_gnt_o=0.
  - Counters 0.
  - Reset mid-FILL discards the fill.
- hit = valid_q && tag_q==tag && !flush_i.
- IDLE:
  - req && hit: instr_gnt_o=1 combinationally. Next cycle instr_rvalid_o=1 and instr_rdata_o=selected word of line_q.
  - req && !hit: instr_gnt_o=0, ram_en_o=1, ram_addr_o={tag,4'b0}; next state FILL.
  - No req: ram_en_o=0, no state change.
- FILL (exactly one cycle):
  - ram_en_o=0, instr_gnt_o=0.
  - Capture line_q<=ram_rdata_i and tag_q<=fill tag; valid_q<=!flush_i; next state IDLE.
  - The still-asserted request then hits in IDLE.
- Miss latency: req at cycle 0, RAM enable at cycle 0, gnt at cycle 2, rvalid at cycle 3. Hit latency: gnt at cycle 0, rvalid at cycle 1.
- instr_rvalid_o is high for exactly one cycle per grant; otherwise 0. instr_rdata_o holds its last value when rvalid=0.
- Core contract: instr_addr_i is stable while instr_req_i=1 && instr_gnt_o=0. The bench checks this with an assertion; the block does not.
- flush_i:
  - Clears valid_q at the next edge.
  - Suppresses a same-cycle hit: treated as a miss and a RAM read is issued.
  - Flush during FILL: the captured line is left invalid.
- Back-to-back hits: gnt every cycle, rvalid every cycle, one cycle behind.
- Only one RAM transaction is outstanding at a time; ram_en_o is never high in two consecutive cycles.

Optional Feature:
- Macro: INSTR_LINE_FETCH_STATS_EN.
- Defined:
  - hit_cnt_o increments on each granted hit.
  - miss_cnt_o increments on each RAM read issued.
  - Both wrap at 2^32 and clear on rst_i.
- Undefined: hit_cnt_o and miss_cnt_o are tied to 0; no counter flops.

Test Plan:
- Reset, then req addr 0x0040 with RAM line 0x0F0E..00 → ram_en_o=1/ram_addr_o=0x0040 at cycle 0, gnt at cycle 2, rvalid at cycle 3 with rdata=0x03020100.
- After the fill, req 0x0044, 0x0048, 0x004C back-to-back → gnt every cycle, no ram_en_o, rdata 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
- Req 0x0050 after 0x0040 line held → miss, ram_addr_o=0x0050, held line replaced; re-request 0x0040 → miss again.
- flush_i=1 in the same cycle as a hit to 0x0044 → no gnt, ram_en_o=1; flush during FILL → line not valid, second RAM read issued.
- rst_i asserted during FILL → next cycle rvalid=0, valid_q=0; subsequent req to the same address misses.
- With INSTR_LINE_FETCH_STATS_EN: 1 miss plus 3 hits → miss_cnt_o=1, hit_cnt_o=4 (the post-fill grant counts as a hit); without the macro, both read 0.
